bcd_char_writer: RTL and testbench

BCD_CHAR_WRITER -- requirements
Module: bcd_char_writer

---
 rtl/bcd_char_writer.sv | 171 +++++++++++++++++
 tb/tb_bcd_char_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_char_writer.sv
// Binary-to-glyph character writer for a video overlay.
// Accepts an unsigned binary value, converts it to BCD with a double-dabble
// loop, formats it into glyph indices with leading-zero blanking, and commits
// the result to the overlay cells only on a falling edge of vertical sync so
// the displayed digits never tear mid-frame.
module bcd_char_writer #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned BIN_W      = 20,
    parameter logic [7:0]  DIGIT_BASE = 8'h10,
    parameter logic [7:0]  BLANK_CODE = 8'h00
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  i_vs,
    input  logic                  i_valid,
    input  logic [BIN_W-1:0]      i_value,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic [DIGITS*8-1:0]   o_char_arr
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest value that fits in the available cells; larger inputs clamp here.
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int CNT_W = $clog2(BIN_W + 1);
    // Cells show a lone "0" out of reset.
    localparam logic [DIGITS*8-1:0] RESET_CHARS = {{(DIGITS-1){BLANK_CODE}}, DIGIT_BASE};

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FORMAT,
        WAIT_VS
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIN_W-1:0]     bin_reg;
    logic [BIN_W-1:0]     value_sat;
    logic [63:0]          value_ext;
    logic [DIGITS*4-1:0]  bcd;
    logic [DIGITS*4-1:0]  bcd_adj;
    logic [DIGITS*4-1:0]  bcd_step;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIGITS*8-1:0]  shadow;
    logic [DIGITS*8-1:0]  codes;
    logic [3:0]           digit;
    logic                 seen_nonzero;
    logic                 vs_d0;
    logic                 vs_d1;
    logic                 vs_fall;

    assign value_ext = 64'(i_value);
    assign value_sat = (value_ext > MAX_VAL) ? MAX_VAL[BIN_W-1:0] : i_value;
    assign vs_fall   = vs_d1 & ~vs_d0;

    // State register.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, run BIN_W conversion steps, format, then hold for vsync fall.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = CONVERT;
            CONVERT: if (bit_cnt == CNT_W'(BIN_W - 1)) state_next = FORMAT;
            FORMAT:  state_next = WAIT_VS;
            WAIT_VS: if (vs_fall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs: only an idle block takes new work.
    always_comb begin
        o_ready = (state == IDLE);
        o_busy  = ~o_ready;
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next binary MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_step = (bcd_adj << 1) | {{(DIGITS*4-1){1'b0}}, bin_reg[BIN_W-1]};
    end

    // Glyph formatting, scanning from the most significant digit to blank leading zeros.
    always_comb begin
        codes        = '0;
        digit        = '0;
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd[i*4 +: 4];
            if (digit != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            if (!seen_nonzero && (i != 0)) begin
                codes[i*8 +: 8] = BLANK_CODE;
            end else begin
                codes[i*8 +: 8] = DIGIT_BASE + {4'd0, digit};
            end
        end
    end

    // Conversion datapath: capture, shift-add-3 loop and shadow load.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            bin_reg <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            shadow  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        bin_reg <= value_sat;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    bcd     <= bcd_step;
                    bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                FORMAT: begin
                    shadow <= codes;
                end
                default: begin
                end
            endcase
        end
    end

    // Two-stage vsync capture for falling-edge detection.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vs_d0 <= 1'b0;
            vs_d1 <= 1'b0;
        end else begin
            vs_d0 <= i_vs;
            vs_d1 <= vs_d0;
        end
    end

    // Visible cells update only on a vsync fall while a result is waiting.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            o_char_arr <= RESET_CHARS;
        end else if ((state == WAIT_VS) && vs_fall) begin
            o_char_arr <= shadow;
        end
    end

endmodule

// File: tb/tb_bcd_char_writer.sv
// Self-checking bench for bcd_char_writer with default parameters.
// A behavioural model tracks the expected cells and readiness every cycle;
// directed scenarios also pin the committed cells to hand-computed literals.
module tb_bcd_char_writer;

    localparam int BIN_W = 20;

    logic        pclk;
    logic        rst_n;
    logic        i_vs;
    logic        i_valid;
    logic [19:0] i_value;
    logic        o_ready;
    logic        o_busy;
    logic [47:0] o_char_arr;

    int checks = 0;
    int passes = 0;

    // Model state
    bit          model_valid = 1'b0;
    bit          m_busy;
    bit          m_wait;
    int          m_count;
    bit          m_vs0;
    bit          m_vs1;
    bit          m_fall;
    logic [47:0] m_chars;
    logic [47:0] m_next;

    bcd_char_writer dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .i_vs       (i_vs),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_char_arr (o_char_arr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Expected glyphs straight from decimal arithmetic: clamp, peel digits, blank leading zeros.
    function automatic logic [47:0] expChars(input logic [19:0] v);
        longint unsigned s;
        longint unsigned p;
        logic [47:0]     r;
        s = longint'(v);
        if (s > 999999) s = 999999;
        r = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && s < p) r[i*8 +: 8] = 8'h00;
            else                r[i*8 +: 8] = 8'h10 + 8'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Behavioural model: accept, fixed latency to the vsync wait, commit on a seen fall.
    always @(posedge pclk) begin
        if (!rst_n) begin
            model_valid = 1'b1;
            m_busy      = 1'b0;
            m_wait      = 1'b0;
            m_count     = 0;
            m_vs0       = 1'b0;
            m_vs1       = 1'b0;
            m_chars     = 48'h00_00_00_00_00_10;
            m_next      = '0;
        end else begin
            m_fall = m_vs1 && !m_vs0;
            if (m_wait) begin
                if (m_fall) begin
                    m_chars = m_next;
                    m_wait  = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (m_busy) begin
                m_count = m_count - 1;
                if (m_count == 0) m_wait = 1'b1;
            end else if (i_valid) begin
                m_next  = expChars(i_value);
                m_busy  = 1'b1;
                m_count = BIN_W + 1;
            end
            m_vs1 = m_vs0;
            m_vs0 = i_vs;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling clock edge.
    always @(negedge pclk) begin
        if (model_valid) begin
            checks++;
            if (o_char_arr === m_chars) passes++;
            else $display("[TB] FAIL model_chars: got %h expected %h at %0t", o_char_arr, m_chars, $time);
            checks++;
            if (o_ready === !m_busy) passes++;
            else $display("[TB] FAIL model_ready: got %b expected %b at %0t", o_ready, !m_busy, $time);
            checks++;
            if (o_busy === m_busy) passes++;
            else $display("[TB] FAIL model_busy: got %b expected %b at %0t", o_busy, m_busy, $time);
        end
    end

    task automatic applyStimulus(input logic [19:0] v);
        @(negedge pclk);
        i_valid = 1'b1;
        i_value = v;
        @(negedge pclk);
        i_valid = 1'b0;
    endtask

    task automatic pulseVs();
        @(negedge pclk);
        i_vs = 1'b1;
        repeat (3) @(negedge pclk);
        i_vs = 1'b0;
    endtask

    task automatic waitReady(input string name, input int budget);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < budget) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (o_ready === 1'b1) passes++;
        else $display("[TB] FAIL %s: o_ready still %b after %0d cycles, required 1", name, o_ready, budget);
    endtask

    task automatic checkOutput(input string name, input logic [47:0] exp_chars, input logic exp_ready);
        checks++;
        if (o_char_arr === exp_chars) passes++;
        else $display("[TB] FAIL %s chars: got %h required %h", name, o_char_arr, exp_chars);
        checks++;
        if (o_ready === exp_ready) passes++;
        else $display("[TB] FAIL %s ready: got %b required %b", name, o_ready, exp_ready);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_vs    = 1'b0;
        i_valid = 1'b0;
        i_value = '0;

        // Reset held for three cycles
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        checkOutput("reset", 48'h00_00_00_00_00_10, 1'b1);

        // 12345: nothing visible until the vsync fall
        applyStimulus(20'd12345);
        repeat (30) @(negedge pclk);
        checkOutput("12345_hold", 48'h00_00_00_00_00_10, 1'b0);
        pulseVs();
        waitReady("12345_commit", 10);
        checkOutput("12345", 48'h00_11_12_13_14_15, 1'b1);

        // Zero shows a single digit
        applyStimulus(20'd0);
        repeat (25) @(negedge pclk);
        pulseVs();
        waitReady("zero_commit", 10);
        checkOutput("zero", 48'h00_00_00_00_00_10, 1'b1);

        // 100000 with the fall landing on the first possible WAIT_VS cycle
        @(negedge pclk);
        i_vs = 1'b1;
        applyStimulus(20'd100000);
        repeat (20) @(negedge pclk);
        i_vs = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("100000_firstfall", 48'h11_10_10_10_10_10, 1'b1);

        // Saturation
        applyStimulus(20'd1048575);
        repeat (25) @(negedge pclk);
        pulseVs();
        waitReady("sat_commit", 10);
        checkOutput("saturate", 48'h19_19_19_19_19_19, 1'b1);

        // 42 with an ignored 777 and an early vsync fall during conversion
        applyStimulus(20'd42);
        @(negedge pclk);
        i_valid = 1'b1;
        i_value = 20'd777;
        i_vs    = 1'b1;
        repeat (2) @(negedge pclk);
        i_valid = 1'b0;
        repeat (2) @(negedge pclk);
        i_vs = 1'b0;
        repeat (30) @(negedge pclk);
        checkOutput("early_fall", 48'h19_19_19_19_19_19, 1'b0);
        pulseVs();
        waitReady("42_commit", 10);
        checkOutput("42", 48'h00_00_00_00_14_12, 1'b1);

        // Reset while 999 waits for vsync
        applyStimulus(20'd999);
        repeat (25) @(negedge pclk);
        checkOutput("999_wait", 48'h00_00_00_00_14_12, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
        checkOutput("midreset", 48'h00_00_00_00_00_10, 1'b1);
        pulseVs();
        repeat (6) @(negedge pclk);
        checkOutput("post_reset_fall", 48'h00_00_00_00_00_10, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
